// File: rtl/arith_sfr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arith_sfr_pkg
//  Description : Opcode and FSM state encodings shared by the arithmetic SFR
//                and its test environment.
//  Revision    : 1.0 - initial release
// ============================================================================
package arith_sfr_pkg;

  // Command opcodes (3-bit cmd field); 3'b110 and 3'b111 act as NOP
  localparam logic [2:0] CMD_NOP  = 3'b000;
  localparam logic [2:0] CMD_LOAD = 3'b001;
  localparam logic [2:0] CMD_ADD  = 3'b010;
  localparam logic [2:0] CMD_SUB  = 3'b011;
  localparam logic [2:0] CMD_DIV  = 3'b100;
  localparam logic [2:0] CMD_CLR  = 3'b101;

  // Handshake FSM states
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DIV_RUN  = 2'd1,
    ST_DIV_DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/arith_sfr_divider.sv
`default_nettype none
// ============================================================================
//  Module      : seq_divider
//  Description : Unsigned restoring divider, one quotient bit per cycle.
//                'ready' is raised combinationally during the final iteration
//                so the caller can capture quotient/remainder on that edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_divider #(
  parameter int SIZE = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [SIZE-1:0] dividend,
  input  logic [SIZE-1:0] divisor,
  output logic            ready,
  output logic [SIZE-1:0] quotient,
  output logic [SIZE-1:0] remainder
);

  localparam int CW = $clog2(SIZE);

  logic            r_run;
  logic [CW-1:0]   r_cnt;
  logic [SIZE-1:0] r_rem;
  logic [SIZE-1:0] r_quo;
  logic [SIZE-1:0] r_dsr;

  logic [SIZE:0]   w_shift;
  logic [SIZE:0]   w_trial;
  logic            w_fit;
  logic [SIZE-1:0] w_rem_nxt;
  logic [SIZE-1:0] w_quo_nxt;

  // One restoring step: shift in next dividend bit, keep the trial subtract if non-negative
  always_comb begin
    w_shift   = {r_rem, r_quo[SIZE-1]};
    w_trial   = w_shift - {1'b0, r_dsr};
    w_fit     = ~w_trial[SIZE];
    w_rem_nxt = w_fit ? w_trial[SIZE-1:0] : w_shift[SIZE-1:0];
    w_quo_nxt = {r_quo[SIZE-2:0], w_fit};
  end

  assign ready     = r_run && (r_cnt == CW'(SIZE - 1));
  assign quotient  = w_quo_nxt;
  assign remainder = w_rem_nxt;

  // Iteration counter, partial remainder and quotient shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run <= 1'b0;
      r_cnt <= '0;
      r_rem <= '0;
      r_quo <= '0;
      r_dsr <= '0;
    end else if (start) begin
      r_run <= 1'b1;
      r_cnt <= '0;
      r_rem <= '0;
      r_quo <= dividend;
      r_dsr <= divisor;
    end else if (r_run) begin
      r_rem <= w_rem_nxt;
      r_quo <= w_quo_nxt;
      r_cnt <= r_cnt + 1'b1;
      if (ready) begin
        r_run <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/arith_sfr.sv
`default_nettype none
// ============================================================================
//  Module      : arith_sfr
//  Description : Arithmetic SFR: accumulator Q / remainder R with LOAD, ADD,
//                SUB, CLR and multi-cycle unsigned DIV, optional unsigned
//                saturation, status flags and valid/busy/done handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module arith_sfr
  import arith_sfr_pkg::*;
#(
  parameter int SIZE   = 32,
  parameter bit SAT_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  input  logic [2:0]      cmd,
  input  logic            sat,
  input  logic [SIZE-1:0] D,
  input  logic [SIZE-1:0] S,
  output logic [SIZE-1:0] Q,
  output logic [SIZE-1:0] R,
  output logic            busy,
  output logic            done,
  output logic            zero,
  output logic            carry,
  output logic            ovf,
  output logic            dz
);

  state_t          r_state, w_state_nxt;
  logic [SIZE-1:0] r_q, r_r, w_q_nxt, w_r_nxt;
  logic            r_done, r_zero, r_carry, r_ovf, r_dz;
  logic            w_done_nxt, w_carry_nxt, w_ovf_nxt, w_dz_nxt;

  logic            w_accept;
  logic            w_sat;
  logic            w_div_start;
  logic            w_div_ready;
  logic [SIZE-1:0] w_div_q, w_div_r;
  logic [SIZE:0]   w_sum, w_diff;
  logic            w_add_ovf, w_sub_ovf;

  generate
    if (SAT_EN) begin : g_sat_on
      assign w_sat = sat;
    end else begin : g_sat_off
      assign w_sat = 1'b0;
    end
  endgenerate

  // Carry/borrow falls out as bit SIZE of the widened result
  assign w_sum     = {1'b0, r_q} + {1'b0, S};
  assign w_diff    = {1'b0, r_q} - {1'b0, S};
  assign w_add_ovf = (r_q[SIZE-1] == S[SIZE-1]) && (w_sum[SIZE-1]  != r_q[SIZE-1]);
  assign w_sub_ovf = (r_q[SIZE-1] != S[SIZE-1]) && (w_diff[SIZE-1] != r_q[SIZE-1]);

  // Commands are ignored (not queued) while a divide is iterating
  assign w_accept  = cmd_valid && (r_state != ST_DIV_RUN);

  seq_divider #(.SIZE(SIZE)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (w_div_start),
    .dividend  (r_q),
    .divisor   (S),
    .ready     (w_div_ready),
    .quotient  (w_div_q),
    .remainder (w_div_r)
  );

  // Next-state, datapath and flag selection for the accepted command
  always_comb begin
    w_state_nxt = r_state;
    w_q_nxt     = r_q;
    w_r_nxt     = r_r;
    w_carry_nxt = r_carry;
    w_ovf_nxt   = r_ovf;
    w_dz_nxt    = r_dz;
    w_done_nxt  = 1'b0;
    w_div_start = 1'b0;
    case (r_state)
      ST_DIV_RUN: begin
        if (w_div_ready) begin
          w_q_nxt     = w_div_q;
          w_r_nxt     = w_div_r;
          w_dz_nxt    = 1'b0;
          w_carry_nxt = 1'b0;
          w_ovf_nxt   = 1'b0;
          w_done_nxt  = 1'b1;
          w_state_nxt = ST_DIV_DONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        if (w_accept) begin
          case (cmd)
            CMD_NOP: ;
            CMD_LOAD: begin
              w_q_nxt     = D;
              w_carry_nxt = 1'b0;
              w_ovf_nxt   = 1'b0;
              w_done_nxt  = 1'b1;
            end
            CMD_ADD: begin
              w_q_nxt     = (w_sat && w_sum[SIZE]) ? '1 : w_sum[SIZE-1:0];
              w_carry_nxt = w_sum[SIZE];
              w_ovf_nxt   = w_add_ovf;
              w_done_nxt  = 1'b1;
            end
            CMD_SUB: begin
              w_q_nxt     = (w_sat && w_diff[SIZE]) ? '0 : w_diff[SIZE-1:0];
              w_carry_nxt = w_diff[SIZE];
              w_ovf_nxt   = w_sub_ovf;
              w_done_nxt  = 1'b1;
            end
            CMD_CLR: begin
              w_q_nxt     = '0;
              w_r_nxt     = '0;
              w_carry_nxt = 1'b0;
              w_ovf_nxt   = 1'b0;
              w_done_nxt  = 1'b1;
            end
            CMD_DIV: begin
              if (S == '0) begin
                // Divide by zero completes immediately without iterating
                w_q_nxt     = '1;
                w_r_nxt     = r_q;
                w_dz_nxt    = 1'b1;
                w_carry_nxt = 1'b0;
                w_ovf_nxt   = 1'b0;
                w_done_nxt  = 1'b1;
              end else begin
                w_div_start = 1'b1;
                w_state_nxt = ST_DIV_RUN;
              end
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  // Architectural state and flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_q     <= '0;
      r_r     <= '0;
      r_done  <= 1'b0;
      r_zero  <= 1'b1;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
      r_dz    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_q     <= w_q_nxt;
      r_r     <= w_r_nxt;
      r_done  <= w_done_nxt;
      r_zero  <= (w_q_nxt == '0);
      r_carry <= w_carry_nxt;
      r_ovf   <= w_ovf_nxt;
      r_dz    <= w_dz_nxt;
    end
  end

  assign Q     = r_q;
  assign R     = r_r;
  assign busy  = (r_state == ST_DIV_RUN);
  assign done  = r_done;
  assign zero  = r_zero;
  assign carry = r_carry;
  assign ovf   = r_ovf;
  assign dz    = r_dz;

endmodule
`default_nettype wire

// File: tb/tb_arith_sfr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_arith_sfr
//  Description : Scoreboard bench for arith_sfr (SIZE=8, SAT_EN=1). Directed
//                commands push hand-computed results; a monitor pops and
//                compares on every done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_arith_sfr;
  import arith_sfr_pkg::*;

  localparam int SIZE = 8;

  logic            clk;
  logic            rst_n;
  logic            cmd_valid;
  logic [2:0]      cmd;
  logic            sat;
  logic [SIZE-1:0] D, S, Q, R;
  logic            busy, done, zero, carry, ovf, dz;

  typedef struct packed {
    logic [7:0] q;
    logic [7:0] r;
    logic       z;
    logic       c;
    logic       o;
    logic       dz;
  } exp_t;

  exp_t exp_q[$];
  int   tests   = 0;
  int   fails   = 0;
  int   run_len = 0;
  int   max_run = 0;

  arith_sfr #(.SIZE(SIZE), .SAT_EN(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd       (cmd),
    .sat       (sat),
    .D         (D),
    .S         (S),
    .Q         (Q),
    .R         (R),
    .busy      (busy),
    .done      (done),
    .zero      (zero),
    .carry     (carry),
    .ovf       (ovf),
    .dz        (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic push(input logic [7:0] q, input logic [7:0] r, input logic z,
                      input logic c, input logic o, input logic d);
    exp_t e;
    e.q = q; e.r = r; e.z = z; e.c = c; e.o = o; e.dz = d;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic [2:0] c, input logic [7:0] d, input logic [7:0] s,
                       input logic st);
    cmd_valid = 1'b1; cmd = c; D = d; S = s; sat = st;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; cmd = CMD_NOP; sat = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: pending=%0d required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expected result
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && done) begin
      run_len++;
      if (run_len > max_run) max_run = run_len;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: actual Q=%h required no completion", Q);
      end else begin
        e = exp_q.pop_front();
        check("sb_Q",     32'(Q),     32'(e.q));
        check("sb_R",     32'(R),     32'(e.r));
        check("sb_zero",  32'(zero),  32'(e.z));
        check("sb_carry", 32'(carry), 32'(e.c));
        check("sb_ovf",   32'(ovf),   32'(e.o));
        check("sb_dz",    32'(dz),    32'(e.dz));
      end
    end else begin
      run_len = 0;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int bc;
    int dc;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd = CMD_NOP; sat = 1'b0; D = '0; S = '0;
    repeat (2) @(negedge clk);
    check("rst_Q",     32'(Q),     32'h00);
    check("rst_R",     32'(R),     32'h00);
    check("rst_busy",  32'(busy),  32'h0);
    check("rst_done",  32'(done),  32'h0);
    check("rst_zero",  32'(zero),  32'h1);
    check("rst_carry", 32'(carry), 32'h0);
    check("rst_ovf",   32'(ovf),   32'h0);
    check("rst_dz",    32'(dz),    32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // SUB without and with saturation
    push(8'h05, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0); issue(CMD_LOAD, 8'h05, 8'h00, 1'b0);
    push(8'h02, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0); issue(CMD_SUB,  8'h00, 8'h03, 1'b0);
    push(8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0); issue(CMD_SUB,  8'h00, 8'h03, 1'b0);
    push(8'h02, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0); issue(CMD_LOAD, 8'h02, 8'h00, 1'b0);
    push(8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0); issue(CMD_SUB,  8'h00, 8'h03, 1'b1);

    // ADD: signed overflow, then unsigned saturation
    push(8'h7F, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0); issue(CMD_LOAD, 8'h7F, 8'h00, 1'b0);
    push(8'h80, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0); issue(CMD_ADD,  8'h00, 8'h01, 1'b0);
    push(8'hF0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0); issue(CMD_LOAD, 8'hF0, 8'h00, 1'b0);
    push(8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0); issue(CMD_ADD,  8'h00, 8'h20, 1'b1);
    drain();

    // DIV 100 / 7 with an ignored LOAD while busy
    push(8'h64, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0); issue(CMD_LOAD, 8'h64, 8'h00, 1'b0);
    push(8'h0E, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0); issue(CMD_DIV,  8'h00, 8'h07, 1'b0);
    bc = 0; dc = 0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (busy) bc++;
      if (c == 3) begin cmd_valid = 1'b1; cmd = CMD_LOAD; D = 8'h33; end
      if (c == 4) begin cmd_valid = 1'b0; cmd = CMD_NOP; end
      if (c == 5) check("div_Q_hold", 32'(Q), 32'h64);
      if (done) begin dc = c; break; end
    end
    check("div_busy_cycles", 32'(bc), 32'd8);
    check("div_done_cycle",  32'(dc), 32'd9);
    drain();

    // DIV by zero, then ADD keeps dz
    push(8'h2A, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0); issue(CMD_LOAD, 8'h2A, 8'h00, 1'b0);
    push(8'hFF, 8'h2A, 1'b0, 1'b0, 1'b0, 1'b1); issue(CMD_DIV,  8'h00, 8'h00, 1'b0);
    @(negedge clk);
    check("dz_busy", 32'(busy), 32'h0);
    check("dz_done", 32'(done), 32'h1);
    push(8'h00, 8'h2A, 1'b1, 1'b1, 1'b0, 1'b1); issue(CMD_ADD, 8'h00, 8'h01, 1'b0);
    drain();

    // Asynchronous reset mid-divide
    push(8'h64, 8'h2A, 1'b0, 1'b0, 1'b0, 1'b1); issue(CMD_LOAD, 8'h64, 8'h00, 1'b0);
    drain();
    issue(CMD_DIV, 8'h00, 8'h07, 1'b0);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_Q",    32'(Q),    32'h00);
    check("arst_R",    32'(R),    32'h00);
    check("arst_busy", 32'(busy), 32'h0);
    check("arst_zero", 32'(zero), 32'h1);
    check("arst_dz",   32'(dz),   32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("arst_no_late_done", 32'(done), 32'h0);
    push(8'h11, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0); issue(CMD_LOAD, 8'h11, 8'h00, 1'b0);
    drain();
    @(negedge clk);

    // Back-to-back LOAD / ADD / CLR
    max_run = 0;
    push(8'h10, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0); issue(CMD_LOAD, 8'h10, 8'h00, 1'b0);
    push(8'h11, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0); issue(CMD_ADD,  8'h00, 8'h01, 1'b0);
    push(8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0); issue(CMD_CLR,  8'h00, 8'h00, 1'b0);
    drain();
    @(negedge clk);
    check("b2b_done_run", 32'(max_run), 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/arith_sfr.md
Name: arith_sfr

Overview:
Parametrised arithmetic Special Function Register (SFR); the next generation of the single-operation subtract SFR.
- Holds an accumulator Q and a remainder R.
- Executes LOAD, ADD, SUB, CLR and a multi-cycle unsigned DIV against operand S.
- Supports optional unsigned saturation and produces status flags.
- Sits beside the register file as a memory-mapped SFR and uses a valid/busy/done handshake.

Parameters:
SIZE, 32, datapath width of D, S, Q and R (must be ≥2).
SAT_EN, 1, 1 builds saturation logic; 0 ties saturation off and ignores the sat input.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous reset, active-low
cmd_valid  input  1  command strobe; sampled only while busy=0
cmd  input  3  opcode (encodings under Behaviour)
sat  input  1  saturate ADD/SUB when 1 (effective only if SAT_EN=1)
D  input  SIZE  load value
S  input  SIZE  operand: addend, subtrahend or divisor
Q  output  SIZE  accumulator / quotient
R  output  SIZE  remainder of last DIV
busy  output  1  DIV in progress
done  output  1  one-cycle pulse when an accepted command completes
zero  output  1  Q==0 after last completed command
carry  output  1  ADD carry-out / SUB borrow
ovf  output  1  signed (two's-complement) overflow of last ADD/SUB
dz  output  1  last DIV had S==0

Behaviour:
- Reset (async, rst_n=0): Q=0, R=0, busy=0, done=0, zero=1, carry=0, ovf=0, dz=0; state IDLE. Reset mid-DIV aborts the divide; no partial result is retained.
- Opcodes:
  - 000 NOP
  - 001 LOAD: Q<=D
  - 010 ADD: Q<=Q+S
  - 011 SUB: Q<=Q-S
  - 100 DIV
  - 101 CLR: Q<=0, R<=0
  - 110 and 111 behave as NOP; done does not pulse.
- Acceptance: a command is accepted on a rising edge when cmd_valid=1 and busy=0. cmd_valid while busy=1 is ignored: no queuing, no error.
- Single-cycle ops (LOAD/ADD/SUB/CLR): Q, R and flags update on the accepting edge. done=1 for the following cycle only. Back-to-back commands on consecutive cycles are legal.
- ADD/SUB width rule: computed at SIZE+1 bits. carry = bit SIZE of the result; for SUB, carry=1 means borrow (S>Q unsigned). ovf is the signed overflow of the SIZE-bit result.
- Saturation (sat=1, SAT_EN=1):
  - ADD with carry gives Q=all ones.
  - SUB with borrow gives Q=0.
  - carry and ovf still report the raw, unsaturated result.
- LOAD, CLR and DIV clear carry and ovf. Only DIV writes dz; no other op changes dz.
- zero is recomputed from the new Q on every completed command.
- DIV FSM (states IDLE, DIV_RUN, DIV_DONE):
  - Accept edge: dividend Q and divisor S are captured.
  - If S==0: no iteration. Q<=all ones, R<=captured dividend, dz=1, done next cycle, busy never asserts.
  - Else: enter DIV_RUN with busy=1. Run exactly SIZE restoring shift-subtract iterations, one per cycle.
  - On the final iteration edge: Q<=quotient, R<=remainder, dz=0, state moves to DIV_DONE.
  - DIV_DONE: busy=0, done=1 for one cycle, then IDLE. A command presented in DIV_DONE is accepted.
  - Latency: accept to done = SIZE+1 cycles.
- Q holds its value in every cycle with no completing command. While busy=1, Q shows the pre-divide value.

Decomposition:
- Package arith_sfr_pkg holds:
  - the cmd encodings as localparams: CMD_NOP, CMD_LOAD, CMD_ADD, CMD_SUB, CMD_DIV, CMD_CLR;
  - the state encodings: ST_IDLE, ST_DIV_RUN, ST_DIV_DONE.
- Sub-module seq_divider(SIZE) owns the iteration counter, partial remainder and quotient shift register, with a start/ready interface.
- The top module owns the ADD/SUB datapath, saturation, flags and the handshake FSM.

Test Plan:
- SIZE=8. LOAD D=0x05, then SUB S=0x03, then SUB S=0x03 with sat=0 → Q=0x02 then Q=0xFF with carry=1; repeat the second SUB with sat=1 → Q=0x00, carry=1, zero=1.
- ADD: Q=0x7F, S=0x01, sat=0 → Q=0x80, ovf=1, carry=0. Q=0xF0, S=0x20, sat=1 → Q=0xFF, carry=1.
- DIV: Q=0x64 (100), S=0x07 → busy=1 for 8 cycles, done on cycle 9, Q=0x0E, R=0x02, dz=0. A cmd_valid LOAD issued mid-busy is ignored.
- DIV by zero: Q=0x2A, S=0 → no busy, next cycle done=1, Q=0xFF, R=0x2A, dz=1. A following ADD leaves dz=1.
- Async reset: drop rst_n 4 cycles into a DIV, between clock edges → Q=0, R=0, busy=0, zero=1 immediately. After release, LOAD 0x11 → Q=0x11.
- Back-to-back: LOAD 0x10, ADD 0x01, CLR on consecutive cycles → Q=0x10, 0x11, 0x00, with done high for 3 consecutive cycles.
